image_pattern_gen: RTL and testbench
====================================

Name: image_pattern_gen

Overview:
- Synthetic Bayer pixel-stream source.
- Drives the same dvo/dtypeo/datao stream format that the statistics blocks (image mean, histograms) consume.
- Used as a sensor stand-in for bring-up and as a known-answer source for downstream accumulators.
- Emits framed rows: frame start, row start, pixels, row end, frame end, with programmable blanking.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel on datao.
- NUM_ROWS_WIDTH, 12, width of row counter and num_rows.
- NUM_COLS_WIDTH, 12, width of column counter and num_cols.
- BLANK_WIDTH, 8, width of hblank/vblank counters.

Ports:
- pixclk  in  1  pixel clock; all logic on posedge.
- resetb  in  1  synchronous, active-high reset.
- enable  in  1  level; when high, frames are generated back to back.
- num_rows  in  NUM_ROWS_WIDTH  active rows per frame.
- num_cols  in  NUM_COLS_WIDTH  active columns per row.
- hblank  in  BLANK_WIDTH  idle cycles after each ROW_END.
- vblank  in  BLANK_WIDTH  idle cycles after FRAME_END.
- pattern  in  2  0=constant per Bayer channel, 1=horizontal ramp, 2=checker, 3=noise/reserved.
- chan00, chan01, chan10, chan11  in  PIXEL_WIDTH each  constant values for Bayer sites {row[0],col[0]}.
- dvo  out  1  output data valid.
- dtypeo  out  `DTYPE_WIDTH  word type from dtypes.v.
- datao  out  PIXEL_WIDTH  pixel value; 0 on non-pixel words.
- busy  out  1  high from the FRAME_START word through the end of vblank.
- frame_done  out  1  one-cycle pulse in the cycle FRAME_END is presented.

Behaviour:
- Reset: state=IDLE; dvo=0, dtypeo=0, datao=0, busy=0, frame_done=0; row, col and blank counters cleared.
- All outputs are registered.
- Configuration latch: num_rows, num_cols, hblank, vblank, pattern and chanXX are sampled at IDLE→FSTART and held for the whole frame. Changes mid-frame take effect next frame.
- State machine, one state per cycle unless noted:
  - IDLE: if enable, go to FSTART; else stay.
  - FSTART: dvo=1, dtypeo=`DTYPE_FRAME_START, busy←1. If num_rows==0 go to FEND, else go to RSTART.
  - RSTART: dvo=1, dtypeo=`DTYPE_ROW_START, col←0. If num_cols==0 go to REND, else go to PIX.
  - PIX: dvo=1, dtypeo=`DTYPE_PIXEL, one pixel per cycle, col increments. After col==num_cols-1, go to REND.
  - REND: dvo=1, dtypeo=`DTYPE_ROW_END, row increments. Next is HBLANK if hblank!=0; otherwise FEND when row==num_rows-1, else RSTART.
  - HBLANK: dvo=0 for exactly hblank cycles, then FEND or RSTART as above.
  - FEND: dvo=1, dtypeo=`DTYPE_FRAME_END, frame_done=1. Next is VBLANK (vblank!=0) or the end-of-frame decision.
  - VBLANK: dvo=0 for exactly vblank cycles, then the end-of-frame decision.
  - End-of-frame decision: busy←0; go to FSTART if enable, else IDLE.
- Pixel values, with site = {row[0], col[0]}:
  - pattern 0: chanXX selected by site.
  - pattern 1: datao = col[PIXEL_WIDTH-1:0] + row[PIXEL_WIDTH-1:0], truncated modulo 2^PIXEL_WIDTH.
  - pattern 2: all ones when row[3]^col[3], else 0.
  - pattern 3: 0 unless the optional feature is compiled in.
- enable deasserted mid-frame: the current frame, including vblank, completes; no truncated frames.
- Reset asserted mid-operation: in the next cycle dvo=0 and state=IDLE. The truncated frame is never closed; downstream re-syncs on the next FRAME_START.
- Counters are exactly NUM_ROWS_WIDTH / NUM_COLS_WIDTH wide. num_rows/num_cols at their maximum values must not wrap early.

Optional Feature:
- Macro: IMAGE_PATTERN_GEN_LFSR_EN.
- Defined: pattern 3 outputs the low PIXEL_WIDTH bits of a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1.
  - Seed reloads on reset and at each FSTART.
  - LFSR advances only in PIX cycles, so frames are repeatable.
- Undefined: no LFSR logic; pattern 3 gives datao=0 on pixel words.

Decomposition:
- Word-type codes (`DTYPE_FRAME_START/ROW_START/PIXEL/ROW_END/FRAME_END, `DTYPE_WIDTH) stay in the shared dtypes.v.
- Pattern-select encodings and the LFSR seed/taps go in a shared pattern defines header.
- Shared so checkers and future sensor models decode them identically.
- One natural sub-module: image_pattern_lfsr (step enable, seed load, value out), instantiated only under the macro.

Test Plan:
- Constant Bayer, 4x4, chan=10/20/30/40, hblank=2, vblank=3: 
  - Stream is FRAME_START, then per row ROW_START, 4 pixels, ROW_END, 2 idle.
  - Row0 pixels 10,20,10,20; row1 pixels 30,40,30,40.
  - FRAME_END then 3 idle. Fed to the mean block, the per-channel sums are 40/80/120/160 with count 4.
- Ramp, PIXEL_WIDTH=8, num_cols=300, num_rows=2: row0 col 255=255, col 256=0; row1 col 0=1. Exactly 300 PIXEL words per row.
- enable dropped 5 cycles after FSTART of a 3x3 frame: frame completes with 9 pixels and frame_done pulses once. IDLE follows vblank; no further FSTART.
- resetb asserted during PIX of row 1: next cycle dvo=0 and busy=0. After release with enable=1, a fresh FRAME_START with row 0 data appears.
- num_rows=0: FRAME_START then FRAME_END on consecutive cycles, frame_done=1. num_cols=0, num_rows=2: rows are ROW_START, ROW_END only.
- With IMAGE_PATTERN_GEN_LFSR_EN, pattern 3, two consecutive 4x4 frames: pixel sequences are identical, and the first pixel equals the low byte after one LFSR step from ACE1.

Source files
------------

// File: rtl/image_pattern_gen_pkg.sv
// Shared word-type codes, pattern-select encodings and LFSR constants for the
// synthetic Bayer source; checkers and sensor models decode these identically.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        3
`define DTYPE_FRAME_START  3'd1
`define DTYPE_ROW_START    3'd2
`define DTYPE_PIXEL        3'd3
`define DTYPE_ROW_END      3'd4
`define DTYPE_FRAME_END    3'd5
`endif

package image_pattern_gen_pkg;

    localparam int DTYPE_W = `DTYPE_WIDTH;

    localparam logic [DTYPE_W-1:0] DT_FRAME_START = `DTYPE_FRAME_START;
    localparam logic [DTYPE_W-1:0] DT_ROW_START   = `DTYPE_ROW_START;
    localparam logic [DTYPE_W-1:0] DT_PIXEL       = `DTYPE_PIXEL;
    localparam logic [DTYPE_W-1:0] DT_ROW_END     = `DTYPE_ROW_END;
    localparam logic [DTYPE_W-1:0] DT_FRAME_END   = `DTYPE_FRAME_END;

    localparam logic [1:0] PAT_CONST   = 2'd0;
    localparam logic [1:0] PAT_RAMP    = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_NOISE   = 2'd3;

    // Fibonacci taps 16,14,13,11 -> register bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/image_pattern_lfsr.sv
// Noise source for pattern 3; only present when IMAGE_PATTERN_GEN_LFSR_EN is
// defined. value is the low bits of the state after the next step.
`ifdef IMAGE_PATTERN_GEN_LFSR_EN
module image_pattern_lfsr
    import image_pattern_gen_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             pixclk,
    input  logic             resetb,
    input  logic             load,
    input  logic             step,
    output logic [OUT_W-1:0] value
);

    logic [15:0] q;
    logic [15:0] q_next;

    assign q_next = lfsr_step(q);
    assign value  = q_next[OUT_W-1:0];

    always_ff @(posedge pixclk) begin
        if (resetb || load) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= q_next;
        end
    end

endmodule
`endif

// File: rtl/image_pattern_gen.sv
// Synthetic Bayer frame source emitting the dvo/dtypeo/datao word stream.
// Optional LFSR noise for pattern 3 is enabled by IMAGE_PATTERN_GEN_LFSR_EN.
module image_pattern_gen
    import image_pattern_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH    = 8,
    parameter int NUM_ROWS_WIDTH = 12,
    parameter int NUM_COLS_WIDTH = 12,
    parameter int BLANK_WIDTH    = 8
) (
    input  logic                      pixclk,
    input  logic                      resetb,
    input  logic                      enable,
    input  logic [NUM_ROWS_WIDTH-1:0] num_rows,
    input  logic [NUM_COLS_WIDTH-1:0] num_cols,
    input  logic [BLANK_WIDTH-1:0]    hblank,
    input  logic [BLANK_WIDTH-1:0]    vblank,
    input  logic [1:0]                pattern,
    input  logic [PIXEL_WIDTH-1:0]    chan00,
    input  logic [PIXEL_WIDTH-1:0]    chan01,
    input  logic [PIXEL_WIDTH-1:0]    chan10,
    input  logic [PIXEL_WIDTH-1:0]    chan11,
    output logic                      dvo,
    output logic [DTYPE_W-1:0]        dtypeo,
    output logic [PIXEL_WIDTH-1:0]    datao,
    output logic                      busy,
    output logic                      frame_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FSTART = 3'd1;
    localparam logic [2:0] S_RSTART = 3'd2;
    localparam logic [2:0] S_PIX    = 3'd3;
    localparam logic [2:0] S_REND   = 3'd4;
    localparam logic [2:0] S_HBLANK = 3'd5;
    localparam logic [2:0] S_FEND   = 3'd6;
    localparam logic [2:0] S_VBLANK = 3'd7;

    logic [2:0]                       state, nxt_state;
    logic [NUM_ROWS_WIDTH-1:0]        row, nxt_row, row_inc, cfg_rows;
    logic [NUM_COLS_WIDTH-1:0]        col, nxt_col, cfg_cols;
    logic [BLANK_WIDTH-1:0]           blank, nxt_blank, cfg_hblank, cfg_vblank;
    logic [1:0]                       cfg_pattern;
    logic [3:0][PIXEL_WIDTH-1:0]      cfg_chan;
    logic                             load_cfg;
    logic                             nxt_dvo;
    logic [DTYPE_W-1:0]               nxt_dtype;
    logic [PIXEL_WIDTH-1:0]           pix_val, noise_val;

    assign row_inc = row + NUM_ROWS_WIDTH'(1);

    always_comb begin
        nxt_state = state;
        nxt_row   = row;
        nxt_col   = col;
        nxt_blank = blank;
        load_cfg  = 1'b0;
        case (state)
            S_IDLE: begin
                nxt_row = '0;
                if (enable) begin
                    nxt_state = S_FSTART;
                    load_cfg  = 1'b1;
                end
            end
            S_FSTART: begin
                nxt_row   = '0;
                nxt_col   = '0;
                nxt_state = (cfg_rows == '0) ? S_FEND : S_RSTART;
            end
            S_RSTART: begin
                nxt_col   = '0;
                nxt_state = (cfg_cols == '0) ? S_REND : S_PIX;
            end
            S_PIX: begin
                if (col == cfg_cols - NUM_COLS_WIDTH'(1)) nxt_state = S_REND;
                else                                      nxt_col   = col + NUM_COLS_WIDTH'(1);
            end
            // row is advanced here, so "last row done" is row == cfg_rows from now on
            S_REND: begin
                nxt_row = row_inc;
                if (cfg_hblank != '0) begin
                    nxt_state = S_HBLANK;
                    nxt_blank = cfg_hblank - BLANK_WIDTH'(1);
                end else begin
                    nxt_state = (row_inc == cfg_rows) ? S_FEND : S_RSTART;
                end
            end
            S_HBLANK: begin
                if (blank == '0) nxt_state = (row == cfg_rows) ? S_FEND : S_RSTART;
                else             nxt_blank = blank - BLANK_WIDTH'(1);
            end
            S_FEND: begin
                if (cfg_vblank != '0) begin
                    nxt_state = S_VBLANK;
                    nxt_blank = cfg_vblank - BLANK_WIDTH'(1);
                end else begin
                    nxt_state = enable ? S_FSTART : S_IDLE;
                    load_cfg  = enable;
                end
            end
            S_VBLANK: begin
                if (blank == '0) begin
                    nxt_state = enable ? S_FSTART : S_IDLE;
                    load_cfg  = enable;
                end else begin
                    nxt_blank = blank - BLANK_WIDTH'(1);
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        nxt_dvo   = 1'b1;
        nxt_dtype = '0;
        case (nxt_state)
            S_FSTART: nxt_dtype = DT_FRAME_START;
            S_RSTART: nxt_dtype = DT_ROW_START;
            S_PIX:    nxt_dtype = DT_PIXEL;
            S_REND:   nxt_dtype = DT_ROW_END;
            S_FEND:   nxt_dtype = DT_FRAME_END;
            default:  nxt_dvo   = 1'b0;
        endcase
    end

    // Pixel for the word being registered, so it follows nxt_row/nxt_col.
    always_comb begin
        pix_val = '0;
        case (cfg_pattern)
            PAT_CONST:   pix_val = cfg_chan[{nxt_row[0], nxt_col[0]}];
            PAT_RAMP:    pix_val = nxt_col[PIXEL_WIDTH-1:0] + nxt_row[PIXEL_WIDTH-1:0];
            PAT_CHECKER: pix_val = (nxt_row[3] ^ nxt_col[3]) ? '1 : '0;
            default:     pix_val = noise_val;
        endcase
    end

`ifdef IMAGE_PATTERN_GEN_LFSR_EN
    image_pattern_lfsr #(.OUT_W(PIXEL_WIDTH)) u_lfsr (
        .pixclk (pixclk),
        .resetb (resetb),
        .load   (nxt_state == S_FSTART),
        .step   (nxt_state == S_PIX),
        .value  (noise_val)
    );
`else
    assign noise_val = '0;
`endif

    always_ff @(posedge pixclk) begin
        if (resetb) begin
            state       <= S_IDLE;
            row         <= '0;
            col         <= '0;
            blank       <= '0;
            dvo         <= 1'b0;
            dtypeo      <= '0;
            datao       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            cfg_rows    <= '0;
            cfg_cols    <= '0;
            cfg_hblank  <= '0;
            cfg_vblank  <= '0;
            cfg_pattern <= '0;
            cfg_chan    <= '0;
        end else begin
            state      <= nxt_state;
            row        <= nxt_row;
            col        <= nxt_col;
            blank      <= nxt_blank;
            dvo        <= nxt_dvo;
            dtypeo     <= nxt_dtype;
            datao      <= (nxt_state == S_PIX) ? pix_val : '0;
            busy       <= (nxt_state != S_IDLE);
            frame_done <= (nxt_state == S_FEND);
            if (load_cfg) begin
                cfg_rows    <= num_rows;
                cfg_cols    <= num_cols;
                cfg_hblank  <= hblank;
                cfg_vblank  <= vblank;
                cfg_pattern <= pattern;
                cfg_chan    <= {chan11, chan10, chan01, chan00};
            end
        end
    end

endmodule

// File: tb/tb_image_pattern_gen.sv
// Scoreboard bench for image_pattern_gen: expected words are queued per frame
// and matched (type, data, idle gap, frame_done, busy) as the DUT emits them.
module tb_image_pattern_gen;
    import image_pattern_gen_pkg::*;

    localparam int PW  = 8;
    localparam int NRW = 12;
    localparam int NCW = 12;
    localparam int BW  = 8;

    logic           pixclk = 1'b0;
    logic           resetb = 1'b1;
    logic           enable = 1'b0;
    logic [NRW-1:0] num_rows = '0;
    logic [NCW-1:0] num_cols = '0;
    logic [BW-1:0]  hblank = '0;
    logic [BW-1:0]  vblank = '0;
    logic [1:0]     pattern = '0;
    logic [PW-1:0]  chan00 = '0, chan01 = '0, chan10 = '0, chan11 = '0;
    logic           dvo, busy, frame_done;
    logic [DTYPE_W-1:0] dtypeo;
    logic [PW-1:0]  datao;

    image_pattern_gen #(
        .PIXEL_WIDTH(PW), .NUM_ROWS_WIDTH(NRW), .NUM_COLS_WIDTH(NCW), .BLANK_WIDTH(BW)
    ) dut (
        .pixclk(pixclk), .resetb(resetb), .enable(enable),
        .num_rows(num_rows), .num_cols(num_cols), .hblank(hblank), .vblank(vblank),
        .pattern(pattern), .chan00(chan00), .chan01(chan01), .chan10(chan10), .chan11(chan11),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .busy(busy), .frame_done(frame_done)
    );

    always #5 pixclk = ~pixclk;

    typedef struct {
        int                 gap;
        logic [DTYPE_W-1:0] dt;
        logic [PW-1:0]      data;
    } word_t;

    word_t exp_q[$];
    word_t e;
    int    n_vec = 0, n_err = 0;
    bit    mon_en = 1'b0;
    int    gap = 0, fd_cnt = 0, mrow = 0, mcol = 0;
    int    sums[4], cnts[4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model_pix(input int pat, input int r, input int c,
                                                input logic [15:0] lf);
        case (pat)
            0: case ({r[0], c[0]})
                   2'b00: return chan00;
                   2'b01: return chan01;
                   2'b10: return chan10;
                   default: return chan11;
               endcase
            1: return PW'(r + c);
            2: return (((r ^ c) & 8) != 0) ? {PW{1'b1}} : '0;
`ifdef IMAGE_PATTERN_GEN_LFSR_EN
            default: return lf[PW-1:0];
`else
            default: return '0;
`endif
        endcase
    endfunction

    task automatic push_word(input int g, input logic [DTYPE_W-1:0] dt, input logic [PW-1:0] d);
        word_t w;
        w.gap = g; w.dt = dt; w.data = d;
        exp_q.push_back(w);
    endtask

    // Uses the bench's current configuration variables.
    task automatic push_frame(input int first_gap);
        logic [15:0] lf = 16'hACE1;
        int rows = int'(num_rows), cols = int'(num_cols), hb = int'(hblank);
        push_word(first_gap, DT_FRAME_START, '0);
        for (int r = 0; r < rows; r++) begin
            push_word((r == 0) ? 0 : hb, DT_ROW_START, '0);
            for (int c = 0; c < cols; c++) begin
                lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
                push_word(0, DT_PIXEL, model_pix(int'(pattern), r, c, lf));
            end
            push_word(0, DT_ROW_END, '0);
        end
        push_word((rows == 0) ? 0 : hb, DT_FRAME_END, '0);
    endtask

    always @(negedge pixclk) begin
        if (mon_en) begin
            if (frame_done) fd_cnt++;
            if (dvo) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_word", 32'(dtypeo), 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.gap >= 0) check_val("gap", gap, e.gap);
                    check_val("dtype", 32'(dtypeo), 32'(e.dt));
                    check_val("data", 32'(datao), 32'(e.data));
                    check_val("frame_done", 32'(frame_done), 32'(e.dt == DT_FRAME_END));
                    check_val("busy", 32'(busy), 1);
                end
                case (dtypeo)
                    DT_FRAME_START: mrow = 0;
                    DT_ROW_START:   mcol = 0;
                    DT_PIXEL: begin
                        sums[(mrow % 2) * 2 + (mcol % 2)] += int'(datao);
                        cnts[(mrow % 2) * 2 + (mcol % 2)]++;
                        mcol++;
                    end
                    DT_ROW_END:     mrow++;
                    default: ;
                endcase
                gap = 0;
            end else begin
                gap++;
            end
        end
    end

    task automatic clear_stats();
        fd_cnt = 0;
        for (int i = 0; i < 4; i++) begin sums[i] = 0; cnts[i] = 0; end
    endtask

    task automatic pulse_enable();
        @(negedge pixclk) enable = 1'b1;
        @(negedge pixclk) enable = 1'b0;
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge pixclk);
            n++;
            seen = dvo && (dtypeo == DT_FRAME_START);
        end
        check_val({tag, "_fs_seen"}, 32'(seen), 1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < bound) begin
            @(negedge pixclk);
            n++;
        end
        check_val({tag, "_completed"}, 32'(n < bound), 1);
        repeat (8) @(negedge pixclk);
        check_val({tag, "_busy_low"}, 32'(busy), 0);
        check_val({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge pixclk);
        @(negedge pixclk);
        check_val("rst_dvo", 32'(dvo), 0);
        check_val("rst_dtypeo", 32'(dtypeo), 0);
        check_val("rst_datao", 32'(datao), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_frame_done", 32'(frame_done), 0);
        resetb = 1'b0;
        mon_en = 1'b1;

        // constant Bayer 4x4
        num_rows = 4; num_cols = 4; hblank = 2; vblank = 3; pattern = 0;
        chan00 = 10; chan01 = 20; chan10 = 30; chan11 = 40;
        clear_stats();
        push_frame(-1);
        pulse_enable();
        wait_idle("const", 500);
        check_val("sum00", sums[0], 40);
        check_val("sum01", sums[1], 80);
        check_val("sum10", sums[2], 120);
        check_val("sum11", sums[3], 160);
        check_val("cnt00", cnts[0], 4);
        check_val("cnt11", cnts[3], 4);
        check_val("const_fd", fd_cnt, 1);

        // ramp across the 8-bit wrap
        num_rows = 2; num_cols = 300; hblank = 0; vblank = 0; pattern = 1;
        clear_stats();
        push_frame(-1);
        pulse_enable();
        wait_idle("ramp", 2000);
        check_val("ramp_pixels", cnts[0] + cnts[1] + cnts[2] + cnts[3], 600);

        // enable dropped mid-frame
        num_rows = 3; num_cols = 3; hblank = 1; vblank = 2; pattern = 0;
        chan00 = 1; chan01 = 2; chan10 = 3; chan11 = 4;
        clear_stats();
        push_frame(-1);
        @(negedge pixclk) enable = 1'b1;
        wait_fs("endrop");
        repeat (5) @(negedge pixclk);
        enable = 1'b0;
        wait_idle("endrop", 500);
        check_val("endrop_fd", fd_cnt, 1);
        check_val("endrop_pixels", cnts[0] + cnts[1] + cnts[2] + cnts[3], 9);

        // reset during PIX of row 1
        num_rows = 4; num_cols = 4; hblank = 0; vblank = 0; pattern = 1;
        mon_en = 1'b0;
        @(negedge pixclk) enable = 1'b1;
        wait_fs("rst");
        repeat (9) @(negedge pixclk);
        check_val("rst_pre_dtype", 32'(dtypeo), 32'(DT_PIXEL));
        check_val("rst_pre_data", 32'(datao), 2);
        resetb = 1'b1;
        @(negedge pixclk);
        check_val("rst_mid_dvo", 32'(dvo), 0);
        check_val("rst_mid_busy", 32'(busy), 0);
        exp_q.delete();
        clear_stats();
        push_frame(-1);
        mon_en = 1'b1;
        resetb = 1'b0;
        wait_fs("rst_restart");
        enable = 1'b0;
        wait_idle("rst_restart", 500);

        // zero rows
        num_rows = 0; num_cols = 5; hblank = 1; vblank = 0; pattern = 0;
        clear_stats();
        push_frame(-1);
        pulse_enable();
        wait_idle("rows0", 200);
        check_val("rows0_fd", fd_cnt, 1);

        // zero columns
        num_rows = 2; num_cols = 0; hblank = 1; vblank = 1;
        push_frame(-1);
        pulse_enable();
        wait_idle("cols0", 200);

        // checker across the bit-3 boundaries
        num_rows = 12; num_cols = 20; hblank = 0; vblank = 1; pattern = 2;
        push_frame(-1);
        pulse_enable();
        wait_idle("checker", 1000);

        // pattern 3, two back-to-back frames must be identical
        num_rows = 4; num_cols = 4; hblank = 1; vblank = 2; pattern = 3;
        clear_stats();
        push_frame(-1);
        push_frame(2);
        @(negedge pixclk) enable = 1'b1;
        wait_fs("noise1");
        wait_fs("noise2");
        enable = 1'b0;
        wait_idle("noise", 500);
        check_val("noise_fd", fd_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
